// File: rtl/car_motion_ctl.sv
// Per-axis car motion engine: independent X/Y speed ramps with braking, 8-way heading,
// wall-hit pulse and a freeze input. Axis index 0 is X, index 1 is Y.
module car_motion_ctl #(
  parameter int unsigned SCREEN_W   = 1024,
  parameter int unsigned SCREEN_H   = 768,
  parameter int unsigned CAR_W      = 64,
  parameter int unsigned CAR_H      = 64,
  parameter int unsigned X_INIT     = 300,
  parameter int unsigned Y_INIT     = 250,
  parameter int unsigned DELAY_MIN  = 100000,
  parameter int unsigned DELAY_MAX  = 400000,
  parameter int unsigned DELAY_STEP = 10000,
  parameter int unsigned TW         = 24,
  parameter int unsigned PW         = 11
) (
  input  logic          pclk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic [3:0]    key_i,
  output logic [PW-1:0] xpos_o,
  output logic [PW-1:0] ypos_o,
  output logic [2:0]    move_dir_o,
  output logic          x_moving_o,
  output logic          y_moving_o,
  output logic          wall_hit_o
);

  localparam logic [TW-1:0] DMin      = TW'(DELAY_MIN);
  localparam logic [TW-1:0] DMax      = TW'(DELAY_MAX);
  localparam logic [TW-1:0] DStep     = TW'(DELAY_STEP);
  localparam logic [TW-1:0] DStep2    = TW'(2 * DELAY_STEP);
  // Clamp thresholds, compared before the add/subtract so nothing ever wraps.
  localparam logic [TW-1:0] DAccelLim = TW'(DELAY_MIN + DELAY_STEP);
  localparam logic [TW-1:0] DBrakeLim = TW'(DELAY_MAX - 2 * DELAY_STEP);
  localparam logic [TW-1:0] DCoastLim = TW'(DELAY_MAX - DELAY_STEP);
  localparam logic [TW-1:0] TOne      = TW'(1);
  localparam logic [PW-1:0] POne      = PW'(1);
  localparam logic [PW-1:0] XLim      = PW'(SCREEN_W - CAR_W);
  localparam logic [PW-1:0] YLim      = PW'(SCREEN_H - CAR_H);

  logic [TW-1:0] timer_q [2];
  logic [TW-1:0] timer_d [2];
  logic [TW-1:0] delay_q [2];
  logic [TW-1:0] delay_d [2];
  logic [PW-1:0] pos_q   [2];
  logic [PW-1:0] pos_d   [2];
  logic [1:0]    sign_q, sign_d;   // 1 = negative direction
  logic [1:0]    cmd_act, cmd_neg; // axis has a command / command is negative
  logic [1:0]    stopped, tick, blocked;
  logic [2:0]    dir_q, dir_d;
  logic          x_moving_q, y_moving_q, wall_hit_q;

  // Decode keys into per-axis commands; opposing keys cancel.
  always_comb begin
    cmd_act[0] = key_i[3] ^ key_i[2];
    cmd_neg[0] = key_i[2];
    cmd_act[1] = key_i[0] ^ key_i[1];
    cmd_neg[1] = key_i[0];
  end

  // Per-axis timer, speed ramp and position step.
  always_comb begin
    for (int a = 0; a < 2; a++) begin
      timer_d[a] = timer_q[a];
      delay_d[a] = delay_q[a];
      pos_d[a]   = pos_q[a];
      sign_d[a]  = sign_q[a];
      blocked[a] = 1'b0;
      stopped[a] = (delay_q[a] == DMax);
      tick[a]    = stopped[a] || (timer_q[a] >= delay_q[a]);
      if (enable_i) begin
        if (!tick[a]) begin
          timer_d[a] = timer_q[a] + TOne;
        end else begin
          timer_d[a] = '0;
          if (stopped[a]) begin
            if (cmd_act[a]) begin
              sign_d[a]  = cmd_neg[a];
              delay_d[a] = DCoastLim;
            end
          end else if (sign_q[a] ? (pos_q[a] == '0)
                                 : (pos_q[a] >= ((a == 0) ? XLim : YLim))) begin
            blocked[a] = 1'b1;
            delay_d[a] = DMax;
          end else begin
            pos_d[a] = sign_q[a] ? (pos_q[a] - POne) : (pos_q[a] + POne);
            if (cmd_act[a] && (cmd_neg[a] == sign_q[a])) begin
              delay_d[a] = (delay_q[a] <= DAccelLim) ? DMin : (delay_q[a] - DStep);
            end else if (cmd_act[a]) begin
              delay_d[a] = (delay_q[a] >= DBrakeLim) ? DMax : (delay_q[a] + DStep2);
            end else begin
              delay_d[a] = (delay_q[a] >= DCoastLim) ? DMax : (delay_q[a] + DStep);
            end
          end
        end
      end
    end
  end

  // Heading follows any non-empty command; held when both axes are idle.
  always_comb begin
    dir_d = dir_q;
    if (enable_i && (cmd_act != 2'b00)) begin
      case ({cmd_act[0], cmd_neg[0]})
        2'b10:   dir_d = !cmd_act[1] ? 3'd2 : (cmd_neg[1] ? 3'd1 : 3'd3);
        2'b11:   dir_d = !cmd_act[1] ? 3'd6 : (cmd_neg[1] ? 3'd7 : 3'd5);
        default: dir_d = cmd_neg[1] ? 3'd0 : 3'd4;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge pclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q[0] <= '0;
      timer_q[1] <= '0;
      delay_q[0] <= DMax;
      delay_q[1] <= DMax;
      pos_q[0]   <= PW'(X_INIT);
      pos_q[1]   <= PW'(Y_INIT);
      sign_q     <= 2'b00;
      dir_q      <= 3'd4;
      x_moving_q <= 1'b0;
      y_moving_q <= 1'b0;
      wall_hit_q <= 1'b0;
    end else begin
      timer_q[0] <= timer_d[0];
      timer_q[1] <= timer_d[1];
      delay_q[0] <= delay_d[0];
      delay_q[1] <= delay_d[1];
      pos_q[0]   <= pos_d[0];
      pos_q[1]   <= pos_d[1];
      sign_q     <= sign_d;
      dir_q      <= dir_d;
      x_moving_q <= (delay_d[0] != DMax);
      y_moving_q <= (delay_d[1] != DMax);
      wall_hit_q <= enable_i && (blocked != 2'b00);
    end
  end

  assign xpos_o     = pos_q[0];
  assign ypos_o     = pos_q[1];
  assign move_dir_o = dir_q;
  assign x_moving_o = x_moving_q;
  assign y_moving_o = y_moving_q;
  assign wall_hit_o = wall_hit_q;

endmodule
